// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a credit-limited request
// stream, an in-order response FIFO and redirect/halt handling.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   redirect_valid, redirect_pc   PC redirect (jal/jalr/taken branch)
//   halt                          stop fetching; drain the queue, exit via reset
//   imem_req_*                    fetch request (valid/addr/ready)
//   imem_resp_*                   in-order read response (valid/data)
//   inst_valid/pc/data, ready     instruction queue head to downstream
//   perf_redirects, perf_empty_cycles
//                                 saturating counters, only when the macro
//                                 FETCH_PERF_CNT_EN is defined
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_empty_cycles,
`endif
    input  logic        inst_ready
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_STOP  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   resp_pc, resp_pc_nxt;     // PC of the oldest non-stale in-flight request
    logic [CW-1:0] fifo_count, fifo_count_nxt;
    logic [CW-1:0] inflight, inflight_nxt;
    logic [CW-1:0] stale, stale_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];

    logic credit_ok, redirect_take, req_fire, resp_take, resp_stale, push, pop;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Handshake qualifiers and head-of-queue outputs
    always_comb begin
        credit_ok      = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);
        redirect_take  = redirect_valid && (state != S_STOP) && !reset;
        imem_req_valid = !reset && (state == S_FETCH) && !redirect_valid && !halt && credit_ok;
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_take      = imem_resp_valid && (inflight != '0);
        resp_stale     = resp_take && (stale != '0);
        push           = resp_take && !resp_stale && !redirect_take;
        inst_valid     = !reset && (fifo_count != '0);
        pop            = inst_valid && inst_ready && !redirect_take;
        inst_pc        = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
        inst_data      = inst_valid ? fifo_data[rd_ptr] : 32'h0;
    end

    // Next-state and bookkeeping
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        resp_pc_nxt    = resp_pc;
        fifo_count_nxt = fifo_count;
        inflight_nxt   = inflight;
        stale_nxt      = stale;
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;

        if (redirect_take) begin
            // Everything still outstanding becomes stale; a response landing
            // this cycle is consumed here rather than counted as stale.
            fifo_count_nxt = '0;
            wr_ptr_nxt     = '0;
            rd_ptr_nxt     = '0;
            fetch_pc_nxt   = {redirect_pc[31:2], 2'b00};
            resp_pc_nxt    = {redirect_pc[31:2], 2'b00};
            inflight_nxt   = inflight - CW'(resp_take);
            stale_nxt      = inflight - CW'(resp_take);
            state_nxt      = (stale_nxt != '0) ? S_DRAIN : S_FETCH;
        end else begin
            if (req_fire) fetch_pc_nxt = fetch_pc + 32'd4;
            inflight_nxt = inflight + CW'(req_fire) - CW'(resp_take);
            if (resp_stale) stale_nxt = stale - CW'(1);
            if (push) begin
                wr_ptr_nxt  = wr_ptr + AW'(1);
                resp_pc_nxt = resp_pc + 32'd4;
            end
            if (pop) rd_ptr_nxt = rd_ptr + AW'(1);
            fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);
            if ((state == S_DRAIN) && (stale_nxt == '0)) state_nxt = S_FETCH;
        end

        if (halt && (state != S_STOP)) state_nxt = S_STOP;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            fifo_count <= '0;
            inflight   <= '0;
            stale      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            resp_pc    <= resp_pc_nxt;
            fifo_count <= fifo_count_nxt;
            inflight   <= inflight_nxt;
            stale      <= stale_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
        end
    end

    // Queue storage; contents are qualified by fifo_count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_data[wr_ptr] <= imem_resp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_redirects    <= 32'h0;
            perf_empty_cycles <= 32'h0;
        end else begin
            if (redirect_take && (perf_redirects != 32'hFFFF_FFFF))
                perf_redirects <= perf_redirects + 32'd1;
            if (!inst_valid && (perf_empty_cycles != 32'hFFFF_FFFF))
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a 1-cycle memory model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_empty_cycles;
`endif

    logic        mem_hold;
    logic [31:0] mem_a;
    logic [31:0] mq[$];   // accepted, not yet answered request addresses
    logic [31:0] rq[$];   // log of accepted request addresses
    logic [31:0] dq[$];   // log of delivered PCs
    logic [31:0] dd[$];   // log of delivered data
    int          total;
    int          bad;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
`ifdef FETCH_PERF_CNT_EN
        .perf_redirects  (perf_redirects),
        .perf_empty_cycles(perf_empty_cycles),
`endif
        .inst_ready      (inst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Memory image: word at address a holds 0x1000_0000 + a; answers one cycle after acceptance
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
            if (!mem_hold && mq.size() > 0) begin
                mem_a = mq.pop_front();
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= 32'h1000_0000 + mem_a;
            end else begin
                imem_resp_valid <= 1'b0;
                imem_resp_data  <= 32'h0;
            end
        end
    end

    // Transaction logs
    always @(posedge clk) begin
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) rq.push_back(imem_req_addr);
            if (inst_valid && inst_ready && !redirect_valid) begin
                dq.push_back(inst_pc);
                dd.push_back(inst_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rq.delete();
        dq.delete();
        dd.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
        #1;
    endtask

    task automatic wait_deliv(input string tag, input int n, input int budget);
        int k = 0;
        while (dq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(dq.size() >= n), 32'd1);
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        int k = 0;
        while (rq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(rq.size() >= n), 32'd1);
    endtask

    initial begin
        int nreq;
        int nlow;
        int k;
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_hold       = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        reset = 1'b0;
        clear_logs();
        #1;
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);

        // Streaming with 1-cycle memory
        wait_deliv("stream_wait", 4, 40);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stream_pc%0d", i), (dq.size() > i) ? dq[i] : 32'hX, 32'(4 * i));
            chk($sformatf("stream_data%0d", i), (dd.size() > i) ? dd[i] : 32'hX,
                32'h1000_0000 + 32'(4 * i));
        end

        // Backpressure: the credit limit stops fetch at two outstanding words
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("bp_req_count", 32'(rq.size()), 32'd2);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_inst_valid", 32'(inst_valid), 32'd1);
        chk("bp_inst_pc", inst_pc, 32'h0);
        chk("bp_inst_data", inst_data, 32'h1000_0000);
        inst_ready = 1'b1;
        wait_reqs("bp_resume_wait", 3, 20);
        chk("bp_resume_addr", (rq.size() > 2) ? rq[2] : 32'hX, 32'h8);
        wait_deliv("bp_deliv_wait", 3, 20);
        chk("bp_deliv_pc2", (dq.size() > 2) ? dq[2] : 32'hX, 32'h8);

        // Redirect with two requests in flight; late responses are discarded
        mem_hold = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("rd_inflight_reqs", 32'(rq.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        dq.delete();
        dd.delete();
        #1;
        chk("rd_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        #1;
        chk("rd_drain_no_req", 32'(imem_req_valid), 32'd0);
        wait_deliv("rd_wait", 3, 30);
        chk("rd_first_pc", (dq.size() > 0) ? dq[0] : 32'hX, 32'h100);
        chk("rd_first_data", (dd.size() > 0) ? dd[0] : 32'hX, 32'h1000_0100);
        chk("rd_first_req", (rq.size() > 2) ? rq[2] : 32'hX, 32'h100);
        nlow = 0;
        foreach (dq[i]) if (dq[i] < 32'h100) nlow++;
        chk("rd_no_stale", 32'(nlow), 32'd0);

        // Redirect near the top of memory: word alignment and address wrap
        nreq = rq.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        dq.delete();
        dd.delete();
        tick();
        redirect_valid = 1'b0;
        wait_deliv("wrap_wait", 2, 30);
        chk("wrap_pc0", (dq.size() > 0) ? dq[0] : 32'hX, 32'hFFFF_FFFC);
        chk("wrap_pc1", (dq.size() > 1) ? dq[1] : 32'hX, 32'h0);
        chk("wrap_req0", (rq.size() > nreq) ? rq[nreq] : 32'hX, 32'hFFFF_FFFC);

        // Redirect together with a response and a head handshake
        do_reset();
        k = 0;
        while (!(inst_valid && imem_resp_valid) && k < 20) begin
            tick();
            k++;
        end
        chk("coinc_found", 32'(inst_valid && imem_resp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        dq.delete();
        dd.delete();
        #1;
        chk("coinc_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("coinc_flushed", 32'(inst_valid), 32'd0);
        chk("coinc_flushed_pc", inst_pc, 32'h0);
        chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
        chk("coinc_req_addr", imem_req_addr, 32'h200);
        wait_deliv("coinc_wait", 1, 20);
        chk("coinc_first_pc", (dq.size() > 0) ? dq[0] : 32'hX, 32'h200);

        // Redirect with a response arriving and one more still in flight
        mem_hold = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("st1_inflight_reqs", 32'(rq.size()), 32'd2);
        mem_hold = 1'b0;
        tick();
        mem_hold       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        dq.delete();
        dd.delete();
        chk("st1_resp_now", 32'(imem_resp_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        #1;
        chk("st1_drain", 32'(imem_req_valid), 32'd0);
        tick();
        chk("st1_drain2", 32'(imem_req_valid), 32'd0);
        tick();
        chk("st1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("st1_req_addr", imem_req_addr, 32'h300);
        chk("st1_no_deliv", 32'(dq.size()), 32'd0);
        chk("st1_inst_valid", 32'(inst_valid), 32'd0);

        // Halt with a full queue: no more fetch, queue drains, redirect ignored
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("halt_full", 32'(inst_valid), 32'd1);
        halt = 1'b1;
        #1;
        chk("halt_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        halt = 1'b0;
        nreq = rq.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        dq.delete();
        dd.delete();
        for (int i = 0; i < 8; i++) tick();
        chk("halt_req_count", 32'(rq.size() - nreq), 32'd0);
        chk("halt_deliv_count", 32'(dq.size()), 32'd2);
        chk("halt_pc0", (dq.size() > 0) ? dq[0] : 32'hX, 32'h0);
        chk("halt_pc1", (dq.size() > 1) ? dq[1] : 32'hX, 32'h4);
        chk("halt_data1", (dd.size() > 1) ? dd[1] : 32'hX, 32'h1000_0004);
        chk("halt_empty", 32'(inst_valid), 32'd0);
        chk("halt_empty_pc", inst_pc, 32'h0);
        chk("halt_stop_req", 32'(imem_req_valid), 32'd0);

        // Reset out of STOP
        reset = 1'b1;
        #1;
        chk("rst_mid_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_restart", 32'(imem_req_valid), 32'd1);
        chk("rst_mid_addr", imem_req_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        // Redirect counter
        do_reset();
        chk("perf_rst", perf_redirects, 32'd0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) tick();
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_1000 + 32'(r * 16'h100);
            tick();
            redirect_valid = 1'b0;
        end
        tick();
        chk("perf_redirects", perf_redirects, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, 2, instruction-queue entries; power of 2, range 2..8.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: redirect_valid  input  1  PC redirect from jal/jalr/taken branch.
REQ-006 Port: redirect_pc  input  32  redirect target.
REQ-007 Port: halt  input  1  ecall seen downstream; stop fetching.
REQ-008 Port: imem_req_valid  output  1  fetch request valid.
REQ-009 Port: imem_req_addr  output  32  fetch address, word aligned.
REQ-010 Port: imem_req_ready  input  1  memory accepts request.
REQ-011 Port: imem_resp_valid  input  1  read data valid; in order, at least 1 cycle after acceptance.
REQ-012 Port: imem_resp_data  input  32  instruction word.
REQ-013 Port: inst_valid  output  1  queue head valid.
REQ-014 Port: inst_pc  output  32  PC of the queue head.
REQ-015 Port: inst_data  output  32  instruction at the queue head.
REQ-016 Port: inst_ready  input  1  downstream consumes the head.

Function
REQ-017 States: FETCH, DRAIN, STOP; request issue is permitted only in FETCH.
REQ-018 imem_req_valid SHALL be 1 iff state==FETCH, redirect_valid==0, halt==0, and fifo_count+inflight < FIFO_DEPTH.
REQ-019 imem_req_addr SHALL equal fetch_pc; on req_valid&&req_ready: fetch_pc += 4 (mod 2^32 wrap) and inflight += 1.
REQ-020 A non-stale response SHALL be written to the FIFO tail with its request PC; inst_valid rises no earlier than the cycle after imem_resp_valid.
REQ-021 Handshake: on inst_valid&&inst_ready, pop the head; push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-022 The credit rule (REQ-018) SHALL prevent FIFO overflow; a response with inflight==0 SHALL be ignored.
REQ-023 Redirect: flush the FIFO; set fetch_pc = {redirect_pc[31:2],2'b00}; stale = inflight minus any response arriving that cycle; next state DRAIN if stale>0, else FETCH.
REQ-024 While stale>0, responses SHALL be discarded, decrementing both stale and inflight; DRAIN→FETCH when stale reaches 0.
REQ-025 A redirect in DRAIN SHALL restart REQ-023 with the current inflight.
REQ-026 Redirect coinciding with an inst handshake, request, or response: redirect wins; no request is issued that cycle; the popped instruction is dropped with the flush.
REQ-027 halt==1 in FETCH or DRAIN → STOP; STOP issues no requests, keeps draining the FIFO to the consumer, ignores redirects, and exits only via reset.
REQ-028 inst_pc and inst_data SHALL be 0 whenever inst_valid==0.

Reset
REQ-029 During and after a reset cycle: state=FETCH, fetch_pc=RESET_PC, FIFO empty, inflight=0, stale=0, all outputs 0, imem_req_valid=0 during the reset cycle.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight fetches; responses to pre-reset requests are the environment's responsibility and need not be absorbed.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN: when defined, add outputs perf_redirects (32) and perf_empty_cycles (32), counting accepted redirects and cycles with inst_valid==0 outside reset; both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-032 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then memory with 1-cycle latency and inst_ready=1 -> inst_pc sequence 0,4,8,12; inst_data matches the memory image.
REQ-034 inst_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests issued, then imem_req_valid=0; raising inst_ready resumes fetch at 0x8.
REQ-035 2 requests in flight, redirect to 0x103 -> both late responses discarded, next inst_pc=0x100, no stale entry is ever presented.
REQ-036 Redirect in the same cycle as a response and an inst handshake -> the FIFO is emptied, stale counts only the remaining in-flight request, and the next request goes to the target.
REQ-037 halt=1 with 2 entries queued -> no further requests; both entries are delivered; a later redirect is ignored.
REQ-038 FETCH_PERF_CNT_EN defined, 3 redirects -> perf_redirects==3; undefined -> build has no perf ports.
